pec_streamer_sink: RTL and testbench

Write-back streamer of the PEC accelerator: collects per-element convolution results from the compute array, quantises them to 4-bit, packs 8 features per 32-bit word and stores them to TCDM through an `hwpe_stream_sink`. It mirrors `pec_streamer_source` on the output side. It runs while the controller executes `OP_COMPUTE`, one output element per burst, and writes the feature map in the same packed layout the source reads, so one layer's output is directly the next layer's input.

---
 rtl/pec_streamer_sink_pkg.sv | 53 +++++
 rtl/pec_streamer_sink_if.sv | 21 ++
 rtl/pec_out_quant.sv | 52 +++++
 rtl/pec_streamer_sink.sv | 146 ++++++++++++++
 tb/tb_pec_streamer_sink.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pec_streamer_sink_pkg.sv
// rtl/pec_streamer_sink_pkg.sv - Types, register view and size helper for the PEC write-back streamer
package pec_streamer_sink_pkg;

    localparam int unsigned PEC_MAX_FT = 16;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_LOAD,
        OP_COMPUTE,
        OP_STORE
    } pec_operation_e;

    typedef enum logic [1:0] {
        CTRL_IDLE,
        CTRL_BUSY,
        CTRL_DONE,
        CTRL_ERROR
    } pec_ctrl_fsm_state_t;

    typedef enum logic [1:0] {
        SNK_IDLE,
        SNK_WAIT,
        SNK_STORE,
        SNK_DRAIN
    } pec_snk_state_e;

    typedef struct packed {
        pec_snk_state_e curr_state;
        pec_snk_state_e next_state;
    } pec_snk_fsm_state_t;

    typedef struct packed {
        pec_operation_e operation;
    } pec_ctrl_reg_t;

    typedef struct packed {
        logic [7:0] ft_sz;
        logic [7:0] in_sz;
        logic [7:0] wg_sz;
    } pec_layer_size_reg_t;

    typedef struct packed {
        pec_ctrl_reg_t       ctrl;
        pec_layer_size_reg_t layer_size;
        logic [31:0]         out_bit_addr;
    } pec_reg2hw_t;

    // Size fields written as 0 are treated as 1 everywhere in the datapath.
    function automatic logic [15:0] size_or_one(input logic [7:0] sz);
        return (sz == 8'd0) ? 16'd1 : {8'd0, sz};
    endfunction

endpackage

// File: rtl/pec_streamer_sink_if.sv
// rtl/pec_streamer_sink_if.sv - TCDM write port between the streamer sink and memory
interface pec_streamer_sink_if;

    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;

    modport master (
        output req, add, wen, be, data,
        input  gnt
    );

    modport slave (
        input  req, add, wen, be, data,
        output gnt
    );

endinterface

// File: rtl/pec_out_quant.sv
// rtl/pec_out_quant.sv - Shift, quantise to 4 bit and pack 16 features into two 32-bit words
// Macro PEC_SINK_RELU_SAT_EN: clamp to [0,15]; otherwise keep the low nibble after the shift.
module pec_out_quant #(
    parameter int unsigned OUT_SHIFT = 4
) (
    input  logic [15:0][15:0] result,
    input  logic [4:0]        ft_sz,
    output logic [1:0][31:0]  words
);

    logic signed [15:0] shifted [16];

    for (genvar f = 0; f < 16; f++) begin : g_shift
        assign shifted[f] = $signed(result[f]) >>> OUT_SHIFT;
    end

    always_comb begin
        logic [63:0] flat;
        logic [3:0]  q;
        flat = '0;
        q    = '0;
        for (int f = 0; f < 16; f++) begin
`ifdef PEC_SINK_RELU_SAT_EN
            if (shifted[f] < 16'sd0) begin
                q = 4'd0;
            end else if (shifted[f] > 16'sd15) begin
                q = 4'd15;
            end else begin
                q = shifted[f][3:0];
            end
`else
            q = shifted[f][3:0];
`endif
            // Nibbles beyond the configured feature count stay zero.
            if (5'(f) < ft_sz) begin
                flat[f*4 +: 4] = q;
            end
        end
        words = flat;
    end

`ifndef PEC_SINK_RELU_SAT_EN
    logic unused_shift_hi;
    always_comb begin
        unused_shift_hi = 1'b0;
        for (int f = 0; f < 16; f++) begin
            unused_shift_hi = unused_shift_hi ^ (^shifted[f][15:4]);
        end
    end
`endif

endmodule

// File: rtl/pec_streamer_sink.sv
// rtl/pec_streamer_sink.sv - PEC write-back streamer: quantise, pack and store output elements to TCDM
// Quantisation mode selected by macro PEC_SINK_RELU_SAT_EN inside pec_out_quant.
module pec_streamer_sink
    import pec_streamer_sink_pkg::*;
#(
    parameter int unsigned OUT_SHIFT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 test_mode_i,
    input  pec_reg2hw_t          reg_file_to_ip_i,
    pec_streamer_sink_if.master  hwpe_tcdm,
    input  pec_ctrl_fsm_state_t  ctrl_fsm_state_i,
    input  logic [15:0][15:0]    result_i,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    output pec_snk_fsm_state_t   snk_fsm_state_o,
    output logic                 snk_done_o
);

    pec_snk_state_e   state;
    pec_snk_state_e   next;
    logic [15:0]      ft_sz;
    logic [15:0]      in_sz;
    logic [15:0]      wg_sz;
    logic [15:0]      el_sz;
    logic [15:0]      n_el;
    logic [15:0]      el_cnt;
    logic [15:0]      el_offset;
    logic [4:0]       ft_eff;
    logic             two_words;
    logic [31:0]      base_addr;
    logic [1:0][31:0] packed_words;
    logic [1:0][31:0] buf_q;
    logic             wd_cnt;
    logic             compute_op;
    logic             accept;
    logic             handshake;
    logic             last_word;
    logic             last_el;

    logic             sink_busy;
    logic             sink_done;
    logic             sink_cnt;
    logic             sink_len;
    logic [31:0]      sink_addr;
    logic             unused_test_mode;

    assign unused_test_mode = test_mode_i;

    assign ft_sz     = size_or_one(reg_file_to_ip_i.layer_size.ft_sz);
    assign in_sz     = size_or_one(reg_file_to_ip_i.layer_size.in_sz);
    assign wg_sz     = size_or_one(reg_file_to_ip_i.layer_size.wg_sz);
    assign ft_eff    = (ft_sz > 16'(PEC_MAX_FT)) ? 5'(PEC_MAX_FT) : ft_sz[4:0];
    assign two_words = (ft_eff > 5'd8);
    assign el_sz     = in_sz - ((wg_sz / 16'd2) * 16'd2);
    assign n_el      = el_sz * el_sz;
    assign last_el   = !(el_cnt < (n_el - 16'd1));

    // Offset stays in 16 bits; only the add to the base pointer is 32-bit.
    assign el_offset = two_words ? (el_cnt << 3) : (el_cnt << 2);
    assign base_addr = reg_file_to_ip_i.out_bit_addr + {16'd0, el_offset};

    assign compute_op = (reg_file_to_ip_i.ctrl.operation == OP_COMPUTE);
    assign accept     = (state == SNK_WAIT) && result_valid_i && !sink_busy;
    assign handshake  = (state == SNK_STORE) && sink_busy && hwpe_tcdm.gnt;
    assign last_word  = handshake && (wd_cnt == two_words);

    assign result_ready_o             = accept;
    assign snk_fsm_state_o.curr_state = state;
    assign snk_fsm_state_o.next_state = next;

    pec_out_quant #(
        .OUT_SHIFT (OUT_SHIFT)
    ) u_quant (
        .result (result_i),
        .ft_sz  (ft_eff),
        .words  (packed_words)
    );

    always_comb begin
        next = state;
        case (state)
            SNK_IDLE:  if (compute_op && ctrl_fsm_state_i == CTRL_BUSY) next = SNK_WAIT;
            SNK_WAIT:  if (accept) next = SNK_STORE;
            SNK_STORE: if (last_word) next = SNK_DRAIN;
            SNK_DRAIN: if (sink_done) next = (last_el || !compute_op) ? SNK_IDLE : SNK_WAIT;
            default:   next = SNK_IDLE;
        endcase
    end

    // Streamer counters plus the sink's TCDM write path: line_stride 4, line_length n_wd.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= SNK_IDLE;
            el_cnt     <= '0;
            wd_cnt     <= 1'b0;
            buf_q      <= '0;
            snk_done_o <= 1'b0;
            sink_busy  <= 1'b0;
            sink_done  <= 1'b0;
            sink_cnt   <= 1'b0;
            sink_len   <= 1'b0;
            sink_addr  <= '0;
        end else begin
            state      <= next;
            snk_done_o <= (state == SNK_DRAIN) && sink_done && last_el;

            if (state == SNK_IDLE) begin
                el_cnt <= '0;
            end else if (state == SNK_DRAIN && sink_done) begin
                el_cnt <= el_cnt + 16'd1;
            end

            if (accept) begin
                buf_q  <= packed_words;
                wd_cnt <= 1'b0;
            end else if (handshake) begin
                wd_cnt <= wd_cnt + 1'b1;
            end

            sink_done <= 1'b0;
            if (accept) begin
                sink_busy <= 1'b1;
                sink_addr <= base_addr;
                sink_cnt  <= 1'b0;
                sink_len  <= two_words;
            end else if (handshake) begin
                sink_addr <= sink_addr + 32'd4;
                sink_cnt  <= sink_cnt + 1'b1;
                if (sink_cnt == sink_len) begin
                    sink_done <= 1'b1;
                end
            end else if (sink_done) begin
                sink_busy <= 1'b0;
            end
        end
    end

    assign hwpe_tcdm.req  = (state == SNK_STORE) && sink_busy;
    assign hwpe_tcdm.add  = sink_addr;
    assign hwpe_tcdm.wen  = 1'b0;
    assign hwpe_tcdm.be   = 4'hF;
    assign hwpe_tcdm.data = buf_q[wd_cnt];

endmodule

// File: tb/tb_pec_streamer_sink.sv
// tb/tb_pec_streamer_sink.sv - Directed self-checking bench for pec_streamer_sink
module tb_pec_streamer_sink;
    import pec_streamer_sink_pkg::*;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                test_mode;
    pec_reg2hw_t         regs;
    pec_ctrl_fsm_state_t ctrl_state;
    logic [15:0][15:0]   result;
    logic                result_valid;
    logic                result_ready;
    pec_snk_fsm_state_t  snk_state;
    logic                snk_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_add[$];
    logic [31:0] wr_data[$];
    int          done_cnt = 0;

    pec_streamer_sink_if tcdm ();

    pec_streamer_sink #(.OUT_SHIFT(4)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .test_mode_i      (test_mode),
        .reg_file_to_ip_i (regs),
        .hwpe_tcdm        (tcdm),
        .ctrl_fsm_state_i (ctrl_state),
        .result_i         (result),
        .result_valid_i   (result_valid),
        .result_ready_o   (result_ready),
        .snk_fsm_state_o  (snk_state),
        .snk_done_o       (snk_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tcdm.req && tcdm.gnt) begin
            wr_add.push_back(tcdm.add);
            wr_data.push_back(tcdm.data);
        end
        if (snk_done) done_cnt++;
    end

    task automatic start_layer(input logic [7:0] ft, input logic [7:0] in_s,
                               input logic [7:0] wg, input logic [31:0] addr);
        regs.layer_size.ft_sz = ft;
        regs.layer_size.in_sz = in_s;
        regs.layer_size.wg_sz = wg;
        regs.out_bit_addr     = addr;
        regs.ctrl.operation   = OP_COMPUTE;
        ctrl_state            = CTRL_BUSY;
    endtask

    task automatic send_element(input logic [15:0][15:0] res, input int max_wait, output bit ok);
        ok = 1'b0;
        @(posedge clk); #1;
        result       = res;
        result_valid = 1'b1;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (result_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        result_valid = 1'b0;
    endtask

    task automatic wait_done(input int max_wait, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (snk_done) begin
                seen = 1'b1;
                break;
            end
        end
        regs.ctrl.operation = OP_IDLE;
        ctrl_state          = CTRL_IDLE;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        test_mode    = 1'b0;
        regs         = '0;
        ctrl_state   = CTRL_IDLE;
        result       = '0;
        result_valid = 1'b0;
        tcdm.gnt     = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (snk_state.curr_state !== SNK_IDLE) begin n_fail++; $display("FAIL reset_curr: got %0d want %0d", snk_state.curr_state, SNK_IDLE); end
        n_checks++; if (snk_state.next_state !== SNK_IDLE) begin n_fail++; $display("FAIL reset_next: got %0d want %0d", snk_state.next_state, SNK_IDLE); end
        n_checks++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", result_ready); end
        n_checks++; if (snk_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", snk_done); end
        n_checks++; if (tcdm.req !== 1'b0 || tcdm.data !== 32'h0 || tcdm.add !== 32'h0) begin n_fail++; $display("FAIL reset_tcdm: req %b add %h data %h want 0", tcdm.req, tcdm.add, tcdm.data); end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++; if (snk_state.curr_state !== SNK_IDLE) begin n_fail++; $display("FAIL idle_after_reset: got %0d want %0d", snk_state.curr_state, SNK_IDLE); end
    endtask

    task automatic test_single_word();
        logic [15:0][15:0] res;
        int wb, db;
        bit ok, seen;
        res = '0;
        for (int f = 0; f < 16; f++) res[f] = (f < 4) ? 16'((f + 1) * 16) : 16'h7FF0;
        wb = wr_add.size(); db = done_cnt;
        start_layer(8'd4, 8'd3, 8'd3, 32'h1000_0000);
        send_element(res, 20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", ok); end
        @(negedge clk);
        n_checks++; if (snk_state.curr_state !== SNK_STORE || tcdm.req !== 1'b1) begin n_fail++; $display("FAIL single_latency: state %0d req %b want %0d 1", snk_state.curr_state, tcdm.req, SNK_STORE); end
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL single_done_seen: got %b want 1", seen); end
        n_checks++; if (wr_add.size() - wb !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", wr_add.size() - wb); end
        else begin
            n_checks++; if (wr_add[wb] !== 32'h1000_0000) begin n_fail++; $display("FAIL single_addr: got %h want 10000000", wr_add[wb]); end
            n_checks++; if (wr_data[wb] !== 32'h0000_4321) begin n_fail++; $display("FAIL single_data: got %h want 00004321", wr_data[wb]); end
        end
        n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt - db); end
        @(negedge clk);
        n_checks++; if (snk_state.curr_state !== SNK_IDLE) begin n_fail++; $display("FAIL single_idle: got %0d want %0d", snk_state.curr_state, SNK_IDLE); end
    endtask

    task automatic test_two_words();
        logic [15:0][15:0] res;
        int wb, db;
        bit ok, seen;
        for (int f = 0; f < 16; f++) res[f] = 16'(f * 16);
        wb = wr_add.size(); db = done_cnt;
        start_layer(8'd16, 8'd4, 8'd3, 32'h0000_2000);
        for (int e = 0; e < 4; e++) begin
            send_element(res, 40, ok);
            n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL two_accept[%0d]: got %b want 1", e, ok); end
        end
        wait_done(40, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL two_done_seen: got %b want 1", seen); end
        n_checks++; if (wr_add.size() - wb !== 8) begin n_fail++; $display("FAIL two_count: got %0d want 8", wr_add.size() - wb); end
        else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (wr_add[wb+i] !== 32'h2000 + 32'(i * 4)) begin n_fail++; $display("FAIL two_addr[%0d]: got %h want %h", i, wr_add[wb+i], 32'h2000 + 32'(i * 4)); end
                n_checks++; if (wr_data[wb+i] !== ((i % 2 == 0) ? 32'h7654_3210 : 32'hFEDC_BA98)) begin n_fail++; $display("FAIL two_data[%0d]: got %h", i, wr_data[wb+i]); end
            end
        end
        n_checks++; if (done_cnt - db !== 1) begin n_fail++; $display("FAIL two_done_cnt: got %0d want 1", done_cnt - db); end
    endtask

    task automatic test_clamp();
        logic [15:0][15:0] res;
        logic [31:0] exp;
        int wb;
        bit ok, seen;
        res    = '0;
        res[0] = 16'hFFE0;
        res[1] = 16'h0190;
`ifdef PEC_SINK_RELU_SAT_EN
        exp = 32'h0000_00F0;
`else
        exp = 32'h0000_009E;
`endif
        wb = wr_add.size();
        start_layer(8'd2, 8'd3, 8'd3, 32'h0000_3000);
        send_element(res, 20, ok);
        wait_done(20, seen);
        n_checks++; if (ok !== 1'b1 || seen !== 1'b1) begin n_fail++; $display("FAIL clamp_flow: accept %b done %b want 1 1", ok, seen); end
        n_checks++; if (wr_data.size() - wb !== 1) begin n_fail++; $display("FAIL clamp_count: got %0d want 1", wr_data.size() - wb); end
        else begin
            n_checks++; if (wr_data[wb] !== exp) begin n_fail++; $display("FAIL clamp_data: got %h want %h", wr_data[wb], exp); end
        end
    endtask

    task automatic test_zero_sizes();
        logic [15:0][15:0] res;
        int wb;
        bit ok, seen;
        res    = '0;
        res[0] = 16'h0050;
        res[1] = 16'h0070;
        wb = wr_add.size();
        start_layer(8'd0, 8'd0, 8'd0, 32'h0000_3800);
        send_element(res, 20, ok);
        wait_done(20, seen);
        n_checks++; if (ok !== 1'b1 || seen !== 1'b1) begin n_fail++; $display("FAIL zero_flow: accept %b done %b want 1 1", ok, seen); end
        n_checks++; if (wr_data.size() - wb !== 1) begin n_fail++; $display("FAIL zero_count: got %0d want 1", wr_data.size() - wb); end
        else begin
            n_checks++; if (wr_data[wb] !== 32'h0000_0005 || wr_add[wb] !== 32'h3800) begin n_fail++; $display("FAIL zero_write: got %h@%h want 00000005@00003800", wr_data[wb], wr_add[wb]); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0][15:0] res;
        int wb;
        bit ok, seen;
        for (int f = 0; f < 16; f++) res[f] = 16'((15 - f) * 16);
        wb = wr_add.size();
        tcdm.gnt = 1'b0;
        start_layer(8'd40, 8'd3, 8'd3, 32'h0000_4000);
        send_element(res, 20, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_accept: got %b want 1", ok); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (tcdm.req !== 1'b1 || tcdm.add !== 32'h4000 || tcdm.data !== 32'h89AB_CDEF) begin
                n_fail++; $display("FAIL bp_hold[%0d]: req %b add %h data %h want 1 00004000 89abcdef", i, tcdm.req, tcdm.add, tcdm.data);
            end
        end
        tcdm.gnt = 1'b1;
        wait_done(20, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", seen); end
        n_checks++; if (wr_add.size() - wb !== 2) begin n_fail++; $display("FAIL bp_count: got %0d want 2", wr_add.size() - wb); end
        else begin
            n_checks++; if (wr_add[wb] !== 32'h4000 || wr_data[wb] !== 32'h89AB_CDEF) begin n_fail++; $display("FAIL bp_word0: got %h@%h", wr_data[wb], wr_add[wb]); end
            n_checks++; if (wr_add[wb+1] !== 32'h4004 || wr_data[wb+1] !== 32'h0123_4567) begin n_fail++; $display("FAIL bp_word1: got %h@%h", wr_data[wb+1], wr_add[wb+1]); end
        end
    endtask

    task automatic test_throttle();
        logic [15:0][15:0] res;
        int wb;
        bit ok, seen;
        res = '0;
        for (int f = 0; f < 4; f++) res[f] = 16'((9 - f) * 16);
        wb = wr_add.size();
        start_layer(8'd4, 8'd3, 8'd3, 32'h0000_5000);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++; if (result_ready !== 1'b0) begin n_fail++; $display("FAIL throttle_ready[%0d]: got %b want 0", i, result_ready); end
        end
        n_checks++; if (snk_state.curr_state !== SNK_WAIT) begin n_fail++; $display("FAIL throttle_wait: got %0d want %0d", snk_state.curr_state, SNK_WAIT); end
        send_element(res, 1, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL throttle_first_accept: got %b want 1", ok); end
        wait_done(20, seen);
        n_checks++; if (wr_data.size() - wb !== 1) begin n_fail++; $display("FAIL throttle_count: got %0d want 1", wr_data.size() - wb); end
        else begin
            n_checks++; if (wr_data[wb] !== 32'h0000_6789) begin n_fail++; $display("FAIL throttle_data: got %h want 00006789", wr_data[wb]); end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0][15:0] res;
        int wb;
        bit ok, seen;
        for (int f = 0; f < 16; f++) res[f] = 16'(f * 16);
        wb = wr_add.size();
        start_layer(8'd16, 8'd4, 8'd3, 32'h0000_6000);
        send_element(res, 20, ok);
        @(posedge clk); #1;
        rst_ni              = 1'b0;
        regs.ctrl.operation = OP_IDLE;
        ctrl_state          = CTRL_IDLE;
        #1;
        n_checks++; if (snk_state.curr_state !== SNK_IDLE) begin n_fail++; $display("FAIL mid_reset_state: got %0d want %0d", snk_state.curr_state, SNK_IDLE); end
        n_checks++; if (tcdm.req !== 1'b0 || tcdm.data !== 32'h0 || tcdm.add !== 32'h0 || result_ready !== 1'b0 || snk_done !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: req %b add %h data %h ready %b done %b want all 0", tcdm.req, tcdm.add, tcdm.data, result_ready, snk_done);
        end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_add.size() - wb !== 1) begin n_fail++; $display("FAIL mid_reset_partial: got %0d want 1", wr_add.size() - wb); end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        wb = wr_add.size();
        start_layer(8'd16, 8'd4, 8'd3, 32'h0000_6000);
        for (int e = 0; e < 4; e++) send_element(res, 40, ok);
        wait_done(40, seen);
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL restart_done: got %b want 1", seen); end
        n_checks++; if (wr_add.size() - wb !== 8) begin n_fail++; $display("FAIL restart_count: got %0d want 8", wr_add.size() - wb); end
        else begin
            n_checks++; if (wr_add[wb] !== 32'h6000 || wr_add[wb+7] !== 32'h601C) begin n_fail++; $display("FAIL restart_addr: first %h last %h want 00006000 0000601c", wr_add[wb], wr_add[wb+7]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_two_words();
        test_clamp();
        test_zero_sizes();
        test_backpressure();
        test_throttle();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
